// File: rtl/mapper_mem_request_pkg.sv
// Shared types and constants for the mapper memory request stage.
package mapper_mem_request_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned WDOG_W = 16;

    localparam logic [DATA_W-1:0] MEM_OPEN_BUS = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } mem_req_state_t;

endpackage

// File: rtl/mem_req_watchdog.sv
// Saturating 16-bit watchdog: counts enabled cycles since the last clear
// and flags when the count equals TIMEOUT.
module mem_req_watchdog
    import mapper_mem_request_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WDOG_W-1:0] LIMIT   = WDOG_W'(TIMEOUT);
    localparam logic [WDOG_W-1:0] CNT_MAX = '1;

    logic [WDOG_W-1:0] count;

    // Cycle counter; clear wins over enable, holds at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + WDOG_W'(1);
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/mapper_mem_request.sv
// Turns each CPU memory cycle (rising edge of ram_cs) into one SDRAM
// request/acknowledge transaction, holding the CPU in wait meanwhile.
// Optional feature: define MEM_READ_CACHE_EN for a single-entry read buffer.
module mapper_mem_request
    import mapper_mem_request_pkg::*;
#(
    parameter int unsigned ADDR_W  = 27,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ram_cs,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic              ram_rnw,
    input  logic [7:0]        cpu_dout,
    output logic              cpu_wait,
    output logic [7:0]        ram_data,
    output logic              sdram_req,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              sdram_we,
    output logic [7:0]        sdram_din,
    input  logic              sdram_ack,
    input  logic [7:0]        sdram_dout,
    output logic              timeout
);

    mem_req_state_t state_q, state_d;

    logic              cs_q;
    logic              start;
    logic              hit;
    logic [7:0]        cache_rdata;
    logic              expired;
    logic              wdog_clear;

    logic              req_d;
    logic [ADDR_W-1:0] addr_d;
    logic              we_d;
    logic [7:0]        din_d;
    logic [7:0]        data_d;
    logic              timeout_d;

`ifdef MEM_READ_CACHE_EN
    logic              cache_valid_q, cache_valid_d;
    logic [ADDR_W-1:0] cache_tag_q,   cache_tag_d;
    logic [7:0]        cache_data_q,  cache_data_d;

    assign hit         = ram_rnw & cache_valid_q & (cache_tag_q == ram_addr);
    assign cache_rdata = cache_data_q;
`else
    assign hit         = 1'b0;
    assign cache_rdata = MEM_OPEN_BUS;
`endif

    assign start    = ram_cs & ~cs_q;
    assign cpu_wait = ram_cs & (((state_q == IDLE) & start & ~hit) | (state_q == REQ));

    mem_req_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wdog_clear),
        .enable  (state_q == REQ),
        .expired (expired)
    );

    // Next-state and next-output logic for the request FSM.
    always_comb begin
        state_d    = state_q;
        req_d      = sdram_req;
        addr_d     = sdram_addr;
        we_d       = sdram_we;
        din_d      = sdram_din;
        data_d     = ram_data;
        timeout_d  = 1'b0;
        wdog_clear = 1'b0;
`ifdef MEM_READ_CACHE_EN
        cache_valid_d = cache_valid_q;
        cache_tag_d   = cache_tag_q;
        cache_data_d  = cache_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (hit) begin
                        data_d  = cache_rdata;
                        state_d = HOLD;
                    end else begin
                        addr_d     = ram_addr;
                        we_d       = ~ram_rnw;
                        din_d      = cpu_dout;
                        req_d      = 1'b1;
                        wdog_clear = 1'b1;
                        state_d    = REQ;
                    end
                end
            end
            REQ: begin
                if (sdram_ack) begin
                    // Ack has priority over a simultaneous watchdog expiry.
                    req_d   = 1'b0;
                    state_d = ram_cs ? HOLD : IDLE;
                    if (!sdram_we && ram_cs) begin
                        data_d = sdram_dout;
                    end
`ifdef MEM_READ_CACHE_EN
                    if (!sdram_we) begin
                        if (ram_cs) begin
                            cache_valid_d = 1'b1;
                            cache_tag_d   = sdram_addr;
                            cache_data_d  = sdram_dout;
                        end
                    end else if (cache_valid_q && (cache_tag_q == sdram_addr)) begin
                        cache_data_d = sdram_din;
                    end
`endif
                end else if (expired) begin
                    req_d     = 1'b0;
                    data_d    = MEM_OPEN_BUS;
                    timeout_d = 1'b1;
                    state_d   = ram_cs ? HOLD : IDLE;
`ifdef MEM_READ_CACHE_EN
                    cache_valid_d = 1'b0;
`endif
                end
            end
            HOLD: begin
                if (!ram_cs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, edge detector and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cs_q       <= 1'b0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            sdram_we   <= 1'b0;
            sdram_din  <= '0;
            ram_data   <= MEM_OPEN_BUS;
            timeout    <= 1'b0;
`ifdef MEM_READ_CACHE_EN
            cache_valid_q <= 1'b0;
            cache_tag_q   <= '0;
            cache_data_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cs_q       <= ram_cs;
            sdram_req  <= req_d;
            sdram_addr <= addr_d;
            sdram_we   <= we_d;
            sdram_din  <= din_d;
            ram_data   <= data_d;
            timeout    <= timeout_d;
`ifdef MEM_READ_CACHE_EN
            cache_valid_q <= cache_valid_d;
            cache_tag_q   <= cache_tag_d;
            cache_data_q  <= cache_data_d;
`endif
        end
    end

endmodule

// File: tb/tb_mapper_mem_request.sv
// Scoreboard bench for mapper_mem_request: the driver pushes expected
// transactions from a reference model, a monitor checks what the DUT does.
module tb_mapper_mem_request;

    localparam int unsigned ADDR_W  = 27;
    localparam int unsigned TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              ram_cs;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rnw;
    logic [7:0]        cpu_dout;
    logic              cpu_wait;
    logic [7:0]        ram_data;
    logic              sdram_req;
    logic [ADDR_W-1:0] sdram_addr;
    logic              sdram_we;
    logic [7:0]        sdram_din;
    logic              sdram_ack;
    logic [7:0]        sdram_dout;
    logic              timeout;

    always #5 clk = ~clk;

    mapper_mem_request #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ram_cs     (ram_cs),
        .ram_addr   (ram_addr),
        .ram_rnw    (ram_rnw),
        .cpu_dout   (cpu_dout),
        .cpu_wait   (cpu_wait),
        .ram_data   (ram_data),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_we   (sdram_we),
        .sdram_din  (sdram_din),
        .sdram_ack  (sdram_ack),
        .sdram_dout (sdram_dout),
        .timeout    (timeout)
    );

    typedef struct {
        bit                hit;
        logic [ADDR_W-1:0] addr;
        bit                we;
        logic [7:0]        din;
        int                len;
        logic [7:0]        data;
        bit                to;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Reference model state: what the CPU would read back, plus the read buffer.
    logic [7:0]        m_data = 8'hFF;
    bit                m_cv   = 1'b0;
    logic [ADDR_W-1:0] m_ct   = '0;
    logic [7:0]        m_cd   = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outcome of one CPU access, from the behavioural rules.
    function automatic exp_t model(input bit rd, input logic [ADDR_W-1:0] addr,
                                   input logic [7:0] wdata, input logic [7:0] rdata,
                                   input int lat, input bit drop);
        exp_t e;
        e.hit  = 1'b0;
        e.addr = addr;
        e.we   = !rd;
        e.din  = wdata;
        e.to   = 1'b0;
        e.len  = 0;
`ifdef MEM_READ_CACHE_EN
        if (rd && m_cv && m_ct == addr) begin
            e.hit  = 1'b1;
            m_data = m_cd;
            e.data = m_data;
            return e;
        end
`endif
        if (lat <= int'(TIMEOUT)) begin
            e.len = lat + 1;
            if (rd) begin
                if (!drop) begin
                    m_data = rdata;
`ifdef MEM_READ_CACHE_EN
                    m_cv = 1'b1;
                    m_ct = addr;
                    m_cd = rdata;
`endif
                end
            end else begin
`ifdef MEM_READ_CACHE_EN
                if (m_cv && m_ct == addr) m_cd = wdata;
`endif
            end
        end else begin
            e.len  = int'(TIMEOUT) + 1;
            e.to   = 1'b1;
            m_data = 8'hFF;
            m_cv   = 1'b0;
        end
        e.data = m_data;
        return e;
    endfunction

    // One CPU access; lat = REQ cycles before ack (beyond TIMEOUT means none),
    // drop_at = REQ cycle index where ram_cs falls (0 = never), hold >= 1.
    task automatic do_txn(input bit rd, input logic [ADDR_W-1:0] addr,
                          input logic [7:0] wdata, input logic [7:0] rdata,
                          input int lat, input int drop_at, input int hold);
        exp_t e;
        e = model(rd, addr, wdata, rdata, lat, drop_at != 0);
        expq.push_back(e);
        ram_cs   = 1'b1;
        ram_addr = addr;
        ram_rnw  = rd;
        cpu_dout = wdata;
        if (!e.hit) begin
            for (int c = 1; c <= e.len; c++) begin
                step();
                if (c == 1) begin
                    ram_addr = ADDR_W'($urandom);
                    cpu_dout = 8'($urandom);
                    ram_rnw  = 1'($urandom);
                end
                if (c == drop_at) ram_cs = 1'b0;
                if (!e.to && c == lat + 1) begin
                    sdram_ack  = 1'b1;
                    sdram_dout = rdata;
                end
            end
        end
        step();
        sdram_ack  = 1'b0;
        sdram_dout = 8'($urandom);
        for (int i = 0; i < hold; i++) step();
        ram_cs = 1'b0;
        repeat ($urandom_range(1, 2)) step();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req"},     32'(sdram_req),  32'd0);
        chk({tag, "_addr"},    32'(sdram_addr), 32'd0);
        chk({tag, "_we"},      32'(sdram_we),   32'd0);
        chk({tag, "_din"},     32'(sdram_din),  32'd0);
        chk({tag, "_data"},    32'(ram_data),   32'hFF);
        chk({tag, "_timeout"}, 32'(timeout),    32'd0);
        chk({tag, "_wait"},    32'(cpu_wait),   32'd0);
    endtask

    // Follows one transaction from the start cycle to one cycle past completion.
    task automatic mon_txn();
        exp_t e;
        int   len;
        if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start: no expected transaction at %0t", $time);
            return;
        end
        e = expq.pop_front();
        chk("start_req_low", 32'(sdram_req), 32'd0);
        chk("start_wait",    32'(cpu_wait),  32'(!e.hit));
        @(negedge clk);
        if (e.hit) begin
            chk("hit_no_req", 32'(sdram_req), 32'd0);
            chk("hit_wait",   32'(cpu_wait),  32'd0);
            chk("hit_data",   32'(ram_data),  32'(e.data));
            return;
        end
        chk("req_rise", 32'(sdram_req),  32'd1);
        chk("req_we",   32'(sdram_we),   32'(e.we));
        if (e.we) chk("req_din", 32'(sdram_din), 32'(e.din));
        len = 0;
        while (sdram_req === 1'b1 && len < 64) begin
            len++;
            chk("req_addr", 32'(sdram_addr), 32'(e.addr));
            chk("req_no_timeout", 32'(timeout), 32'd0);
            if (ram_cs) chk("req_wait", 32'(cpu_wait), 32'd1);
            @(negedge clk);
        end
        chk("req_len",      32'(len),      32'(e.len));
        chk("done_data",    32'(ram_data), 32'(e.data));
        chk("done_timeout", 32'(timeout),  32'(e.to));
        chk("done_wait",    32'(cpu_wait), 32'd0);
        @(negedge clk);
        chk("timeout_one_shot", 32'(timeout), 32'd0);
    endtask

    // Monitor: detects CPU starts and checks the bus is quiet otherwise.
    initial begin
        bit prev_cs;
        prev_cs = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (ram_cs && !prev_cs) mon_txn();
                else chk("idle_quiet", 32'({sdram_req, timeout}), 32'd0);
            end
            prev_cs = ram_cs;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL time_limit: bench did not finish, errors so far %0d", errors);
        $fatal(1, "bench time limit reached");
    end

    // Stimulus.
    initial begin
        bit                rd;
        logic [ADDR_W-1:0] a;
        int                lat, drop, hold;
        reset      = 1'b1;
        ram_cs     = 1'b0;
        ram_addr   = '0;
        ram_rnw    = 1'b1;
        cpu_dout   = '0;
        sdram_ack  = 1'b0;
        sdram_dout = '0;
        step();
        step();
        @(negedge clk);
        chk_reset_values("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();

        // Reset in the middle of a read.
        ram_cs   = 1'b1;
        ram_addr = ADDR_W'(27'h0000055);
        ram_rnw  = 1'b1;
        step();
        @(negedge clk);
        chk("pre_reset_req", 32'(sdram_req), 32'd1);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        ram_cs = 1'b0;
        step();
        @(negedge clk);
        chk_reset_values("mid_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        mon_en = 1'b1;

        do_txn(1'b1, 27'h0004000, 8'h00, 8'h5A, 2, 0, 1);
        do_txn(1'b0, 27'h0000123, 8'hC3, 8'hEE, 0, 0, 1);
        do_txn(1'b1, 27'h0000777, 8'h00, 8'h00, int'(TIMEOUT) + 3, 0, 2);
        do_txn(1'b1, 27'h0000200, 8'h00, 8'h3C, 1, 0, 20);
        do_txn(1'b1, 27'h0000200, 8'h00, 8'h4D, 0, 0, 1);
        do_txn(1'b1, 27'h0000201, 8'h00, 8'h6E, int'(TIMEOUT), 0, 1);
        do_txn(1'b1, 27'h0000300, 8'h00, 8'h99, 3, 2, 1);
        do_txn(1'b1, 27'h0000010, 8'h00, 8'h11, 1, 0, 1);
        do_txn(1'b1, 27'h0000010, 8'h00, 8'h77, 1, 0, 1);
        do_txn(1'b0, 27'h0000010, 8'h22, 8'h00, 0, 0, 1);
        do_txn(1'b1, 27'h0000010, 8'h00, 8'h88, 2, 0, 1);

        for (int n = 0; n < 60; n++) begin
            rd = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       a = 27'h0000010;
                1:       a = 27'h0004000;
                2:       a = 27'h0000123;
                default: a = ADDR_W'($urandom);
            endcase
            lat  = int'($urandom_range(0, 6));
            drop = 0;
            if (lat <= int'(TIMEOUT) && $urandom_range(0, 7) == 0)
                drop = int'($urandom_range(1, lat + 1));
            hold = int'($urandom_range(1, 4));
            do_txn(rd, a, 8'($urandom), 8'($urandom), lat, drop, hold);
        end

        repeat (5) step();
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mapper_mem_request.md
# mapper_mem_request

Downstream stage of the slot mappers: consumes the merged mapper output (RAM chip select, 27-bit linear address, read/not-write) plus CPU write data. It turns each CPU memory cycle into exactly one request/acknowledge transaction to the SDRAM controller. While the transaction is outstanding it holds the CPU in wait and returns read data to the CPU data mux. It sits between the slot/mapper decode and the SDRAM arbiter port.

## Interface
- ADDR_W, 27, linear memory address width; matches mapper `out.addr`.
- TIMEOUT, 255, clocks to wait for `sdram_ack` before aborting; 1..65535.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ram_cs  in  1  mapper `out.ram_cs`.
- ram_addr  in  ADDR_W  mapper `out.addr`.
- ram_rnw  in  1  mapper `out.rnw`; 1 = read, 0 = write.
- cpu_dout  in  8  CPU write data.
- cpu_wait  out  1  CPU wait request.
- ram_data  out  8  read data to CPU mux.
- sdram_req  out  1  request level, held until ack.
- sdram_addr  out  ADDR_W  latched request address.
- sdram_we  out  1  1 = write request.
- sdram_din  out  8  latched write data.
- sdram_ack  in  1  one-clock completion pulse from controller.
- sdram_dout  in  8  read data; valid in the `sdram_ack` cycle.
- timeout  out  1  one-clock pulse on abort.

## Operation
- Access start: `start = ram_cs & ~cs_q`, where `cs_q` is `ram_cs` registered.
- Only the rising edge of `ram_cs` starts an access; a held `ram_cs` never re-triggers.
- States:
  - IDLE: on `start`, latch `ram_addr`, `~ram_rnw` and `cpu_dout` into `sdram_addr`, `sdram_we` and `sdram_din`; set `sdram_req`; clear the watchdog; go to REQ.
  - REQ:
    - On `sdram_ack`: clear `sdram_req`. For a read, capture `sdram_dout` into `ram_data`. Go to HOLD.
    - On watchdog reaching TIMEOUT with no ack: clear `sdram_req`, set `ram_data` = 8'hFF, pulse `timeout`, go to HOLD.
  - HOLD: stay until `ram_cs` = 0, then go to IDLE.
- `cpu_wait = ram_cs & ((state==IDLE & start) | state==REQ)`.
  - It is combinational in the start cycle so the CPU samples wait in the same clock.
- `ram_data` holds its last value outside reads. Writes never modify it, except under the cache rule below.
- Priority rules:
  - Ack and timeout expiry in the same cycle: the ack wins and no `timeout` pulse is issued.
  - `ram_cs` dropping while in REQ: the transaction still completes, since SDRAM requests cannot be cancelled. Read data is discarded and the state goes straight to IDLE.
- Reset: all registers clear and the state returns to IDLE. The SDRAM controller tolerates `sdram_req` dropping mid-transaction.
- Watchdog: 16-bit counter. It saturates and never wraps.

## Timing
- Reset values: `cpu_wait` 0, `ram_data` 8'hFF, `sdram_req` 0, `sdram_addr` 0, `sdram_we` 0, `sdram_din` 0, `timeout` 0. State is IDLE, `cs_q` 0.
- Cycle S (start): `cpu_wait` = 1.
- S+1: `sdram_req` = 1, with `sdram_addr`, `sdram_we` and `sdram_din` stable and held until ack.
- Ack in cycle A:
  - A+1: `sdram_req` = 0, `ram_data` valid, `cpu_wait` = 0.
  - Minimum wait is 2 clocks, when the ack arrives at S+1.
- Timeout: the watchdog counts the REQ cycles without ack. At count TIMEOUT the FSM goes to HOLD on the next clock, and `timeout` is high for that one cycle.
- A new `start` cannot be accepted before HOLD→IDLE. That transition needs `ram_cs` low for at least one clock.

## Configuration
- MEM_READ_CACHE_EN: single-entry read buffer with tag (ADDR_W bits), data (8 bits) and valid flag.
- Defined:
  - Read `start` where `valid & tag == ram_addr`: no SDRAM request, `cpu_wait` stays 0, `ram_data` = cached data in the next cycle, go to HOLD.
  - Completed read miss: loads tag and data and sets valid.
  - Completed write to the tag address: updates the cached data (write-through).
  - Write to any other address: leaves the entry unchanged.
  - Timeout and reset clear valid.
- Undefined: every access goes to SDRAM and the cache registers are absent.

## Structure
- Shared package: the `mem_req_state_t` enum (IDLE, REQ, HOLD) and `MEM_OPEN_BUS` = 8'hFF.
- Sub-module `mem_req_watchdog` provides a clear, an enable, a TIMEOUT compare and an `expired` output.

## Test plan
- Read 27'h0004000, ack at S+3 with `sdram_dout` 8'h5A → `sdram_req` high S+1..S+3, `sdram_we` 0, `ram_data` 8'h5A at S+4, `cpu_wait` low at S+4.
- Write 8'hC3 to 27'h0000123, ack at S+1 → `sdram_we` 1, `sdram_din` 8'hC3, `sdram_req` one cycle, `ram_data` unchanged.
- TIMEOUT=4, no ack → one `timeout` pulse, `ram_data` 8'hFF, `sdram_req` low, `cpu_wait` released.
- `ram_cs` held high for 20 clocks after ack → exactly one request; re-asserted after one low clock → a second request.
- Reset asserted at S+2 of a read → all outputs at reset values next clock; the next `start` is accepted normally.
- MEM_READ_CACHE_EN: read 27'h10 (ack 8'h11), then read 27'h10 again → no second `sdram_req` and `ram_data` 8'h11. Write 8'h22 to 27'h10, then read 27'h10 → 8'h22 with no request.
